// File: rtl/tiled_frame_compositor.sv
// Tiled frame compositor: TILES_X x TILES_Y grid of images from one frame RAM,
// upscaled by 2**SCALE_LOG2, loaded through a valid/ready stream. Tile borders: TILE_BORDER_EN.
module tiled_frame_compositor #(
  parameter int              PIX_W        = 12,
  parameter int              TILE_W       = 160,
  parameter int              TILE_H       = 120,
  parameter int              TILES_X      = 2,
  parameter int              TILES_Y      = 2,
  parameter int              SCALE_LOG2   = 1,
  parameter logic [PIX_W-1:0] BG_COLOR     = 12'h000,
  parameter logic [PIX_W-1:0] BORDER_COLOR = 12'hFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       row,
  input  logic [9:0]       col,
  input  logic             video_on,
  output logic [PIX_W-1:0] pixel,
  output logic             pixel_valid,
  input  logic             load_start,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [PIX_W-1:0] wr_data,
  output logic             loaded
);

  localparam int TILE_SZ = TILE_W * TILE_H;
  localparam int DEPTH   = TILES_X * TILES_Y * TILE_SZ;
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int GRID_W  = TILES_X * TILE_W;
  localparam int GRID_H  = TILES_Y * TILE_H;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } load_state_e;

  load_state_e   state_q, state_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic          wr_en;

  logic [PIX_W-1:0] mem [DEPTH];
  logic [PIX_W-1:0] rd_data_q;

  logic [AW-1:0] s1_addr_q, s1_addr_d;
  logic          s1_in_grid_q, s1_in_grid_d;
  logic          s1_video_q;
  logic          s2_in_grid_q;
  logic          s2_video_q;

  // ---------------------------------------------------------------------------
  // Frame loader
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      waddr_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
      waddr_q <= waddr_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a variable unassigned (no latch).
    state_d = state_q;
    waddr_d = waddr_q;
    wr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d = ST_LOAD;
          waddr_d = '0;
        end
      end
      ST_LOAD: begin
        // A restart takes priority: the beat offered in the same cycle is dropped.
        if (load_start) begin
          waddr_d = '0;
        end else if (wr_valid) begin
          wr_en = 1'b1;
          if (waddr_q == LAST_ADDR) begin
            state_d = ST_DONE;
          end else begin
            waddr_d = waddr_q + AW'(1);
          end
        end
      end
      ST_DONE: begin
        if (load_start) begin
          state_d = ST_LOAD;
          waddr_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign wr_ready = (state_q == ST_LOAD);
  assign loaded   = (state_q == ST_DONE);

  // ---------------------------------------------------------------------------
  // Frame RAM: one write port, one registered read port, read-first.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: the RAM array and its read register carry no reset, so this maps
    // onto block RAM; stale contents are masked by the loaded flag.
    if (wr_en) begin
      mem[waddr_q] <= wr_data;
    end
    rd_data_q <= mem[s1_addr_q];
  end

  // ---------------------------------------------------------------------------
  // Stage 1: screen position -> tile, local coordinates, RAM address
  // ---------------------------------------------------------------------------
  int sx, sy, tx, ty, lx, ly, addr_full;

  always_comb begin
    sx = int'(col) >> SCALE_LOG2;
    sy = int'(row) >> SCALE_LOG2;
    // Tile index by comparing against constant tile boundaries; saturates at the
    // last tile, and anything beyond is rejected by the in-grid test.
    tx = 0;
    for (int k = 1; k < TILES_X; k++) begin
      if (sx >= k * TILE_W) tx = k;
    end
    ty = 0;
    for (int k = 1; k < TILES_Y; k++) begin
      if (sy >= k * TILE_H) ty = k;
    end
    lx        = sx - tx * TILE_W;
    ly        = sy - ty * TILE_H;
    addr_full = (ty * TILES_X + tx) * TILE_SZ + ly * TILE_W + lx;
    s1_in_grid_d = (sx < GRID_W) && (sy < GRID_H);
    s1_addr_d    = s1_in_grid_d ? AW'(addr_full) : '0;
  end

`ifdef TILE_BORDER_EN
  logic s1_border_d, s1_border_q, s2_border_q;

  always_comb begin
    s1_border_d = (lx == 0) || (lx == TILE_W - 1) || (ly == 0) || (ly == TILE_H - 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_border_q <= 1'b0;
      s2_border_q <= 1'b0;
    end else begin
      s1_border_q <= s1_border_d;
      s2_border_q <= s1_border_q;
    end
  end
`else
  logic unused_border;
  assign unused_border = ^BORDER_COLOR;
`endif

  // ---------------------------------------------------------------------------
  // Stage 1/2 flag pipeline (stage 2 runs alongside the RAM read)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_addr_q    <= '0;
      s1_in_grid_q <= 1'b0;
      s1_video_q   <= 1'b0;
      s2_in_grid_q <= 1'b0;
      s2_video_q   <= 1'b0;
    end else begin
      s1_addr_q    <= s1_addr_d;
      s1_in_grid_q <= s1_in_grid_d;
      s1_video_q   <= video_on;
      s2_in_grid_q <= s1_in_grid_q;
      s2_video_q   <= s1_video_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Output select
  // ---------------------------------------------------------------------------
  always_comb begin
    pixel       = '0;
    pixel_valid = s2_video_q;
    if (s2_video_q) begin
      if (!s2_in_grid_q || !loaded) begin
        pixel = BG_COLOR;
      end
`ifdef TILE_BORDER_EN
      else if (s2_border_q) begin
        pixel = BORDER_COLOR;
      end
`endif
      else begin
        pixel = rd_data_q;
      end
    end
  end

endmodule

// File: tb/tb_tiled_frame_compositor.sv
// Scoreboard bench for tiled_frame_compositor: two instances (scale 1x and 2x)
// share one load stream and one VGA stimulus; expected pixels come from a shadow frame.
module tb_tiled_frame_compositor;

  localparam int TW = 4;
  localparam int TH = 2;
  localparam int TX = 2;
  localparam int TY = 2;
  localparam int DEPTH = TX * TY * TW * TH;
  localparam logic [11:0] BG   = 12'h0A5;
  localparam logic [11:0] BORD = 12'hF0F;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  row, col;
  logic        video_on, load_start, wr_valid;
  logic [11:0] wr_data;
  logic [11:0] pixel0, pixel1;
  logic        pv0, pv1, wr_ready, wr_ready1, loaded, loaded1;

  always #5 clk = ~clk;

  tiled_frame_compositor #(
    .PIX_W(12), .TILE_W(TW), .TILE_H(TH), .TILES_X(TX), .TILES_Y(TY),
    .SCALE_LOG2(0), .BG_COLOR(BG), .BORDER_COLOR(BORD)
  ) dut0 (
    .clk(clk), .rst(rst), .row(row), .col(col), .video_on(video_on),
    .pixel(pixel0), .pixel_valid(pv0), .load_start(load_start),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .loaded(loaded)
  );

  tiled_frame_compositor #(
    .PIX_W(12), .TILE_W(TW), .TILE_H(TH), .TILES_X(TX), .TILES_Y(TY),
    .SCALE_LOG2(1), .BG_COLOR(BG), .BORDER_COLOR(BORD)
  ) dut1 (
    .clk(clk), .rst(rst), .row(row), .col(col), .video_on(video_on),
    .pixel(pixel1), .pixel_valid(pv1), .load_start(load_start),
    .wr_valid(wr_valid), .wr_ready(wr_ready1), .wr_data(wr_data), .loaded(loaded1)
  );

  typedef struct {
    int          due;
    int          r;
    int          c;
    logic        v;
    logic [11:0] p;
  } exp_t;

  exp_t        sb0[$];
  exp_t        sb1[$];
  logic [11:0] shadow [DEPTH];
  bit          exp_loaded = 1'b0;
  int          cyc = 0;
  int          vectors = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] model(input int r, input int c, input bit v, input int s);
    int sx, sy, tx, ty, lx, ly;
    if (!v) return 12'h000;
    sx = c >> s;
    sy = r >> s;
    if (sx >= TX * TW || sy >= TY * TH || !exp_loaded) return BG;
    tx = sx / TW;
    ty = sy / TH;
    lx = sx % TW;
    ly = sy % TH;
`ifdef TILE_BORDER_EN
    if (lx == 0 || lx == TW - 1 || ly == 0 || ly == TH - 1) return BORD;
`endif
    return shadow[(ty * TX + tx) * TW * TH + ly * TW + lx];
  endfunction

  // Drive one display position at a negedge and queue what each instance must show.
  task automatic drive_pix(input int r, input int c, input bit v);
    exp_t e;
    row      = 10'(r);
    col      = 10'(c);
    video_on = v;
    e.due = cyc + 2;
    e.r   = r;
    e.c   = c;
    e.v   = v;
    e.p   = model(r, c, v, 0);
    sb0.push_back(e);
    e.p   = model(r, c, v, 1);
    sb1.push_back(e);
    @(negedge clk);
  endtask

  task automatic drain();
    video_on = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Offer n beats (data = base + index) with random gaps; returns at a negedge
  // after the last accepted beat has been clocked in.
  task automatic stream(input int n, input logic [11:0] base, input int gap_pct, output int got);
    int budget;
    got    = 0;
    budget = 0;
    while (got < n && budget < 400) begin
      wr_valid = ($urandom_range(0, 99) >= gap_pct);
      wr_data  = base + 12'(got);
      if (wr_valid && wr_ready) begin
        shadow[got] = wr_data;
        got++;
      end
      budget++;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    if (got != n) begin
      vectors++;
      errors++;
      $display("FAIL stream_timeout beats=%0d required=%0d", got, n);
    end
  endtask

  // Scoreboard monitor: compares 1 ns after the edge that completes each vector.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (sb0.size() > 0 && sb0[0].due <= cyc) begin
        e = sb0.pop_front();
        vectors++;
        if (pixel0 !== e.p || pv0 !== e.v) begin
          errors++;
          $display("FAIL pix_x1 r=%0d c=%0d got pixel=%h valid=%b want pixel=%h valid=%b",
                   e.r, e.c, pixel0, pv0, e.p, e.v);
        end
      end
      while (sb1.size() > 0 && sb1[0].due <= cyc) begin
        e = sb1.pop_front();
        vectors++;
        if (pixel1 !== e.p || pv1 !== e.v) begin
          errors++;
          $display("FAIL pix_x2 r=%0d c=%0d got pixel=%h valid=%b want pixel=%h valid=%b",
                   e.r, e.c, pixel1, pv1, e.p, e.v);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1;
    wr_valid = 1'b1;
    wr_data = 12'h123;
    repeat (2) @(negedge clk);
    vectors++;
    if (pixel0 !== 12'h000) begin errors++; $display("FAIL rst_pixel got=%h want=000", pixel0); end
    vectors++;
    if (pv0 !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b want=0", pv0); end
    vectors++;
    if (wr_ready !== 1'b0) begin errors++; $display("FAIL rst_wr_ready got=%b want=0", wr_ready); end
    vectors++;
    if (loaded !== 1'b0) begin errors++; $display("FAIL rst_loaded got=%b want=0", loaded); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (wr_ready !== 1'b0 || loaded !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignores_wr got wr_ready=%b loaded=%b want 0 0", wr_ready, loaded);
    end
    wr_valid = 1'b0;
    drive_pix(1, 5, 1'b1);
    drain();
  endtask

  task automatic test_load();
    int got;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    vectors++;
    if (wr_ready !== 1'b1 || loaded !== 1'b0) begin
      errors++;
      $display("FAIL load_enter got wr_ready=%b loaded=%b want 1 0", wr_ready, loaded);
    end
    stream(DEPTH - 1, 12'h000, 30, got);
    vectors++;
    if (loaded !== 1'b0 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_before_last got loaded=%b wr_ready=%b want 0 1", loaded, wr_ready);
    end
    wr_valid = 1'b1;
    wr_data  = 12'(DEPTH - 1);
    shadow[DEPTH - 1] = wr_data;
    @(negedge clk);
    vectors++;
    if (loaded !== 1'b1 || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_done got loaded=%b wr_ready=%b want 1 0", loaded, wr_ready);
    end
    vectors++;
    if (loaded1 !== 1'b1) begin errors++; $display("FAIL load_done_x2 got=%b want=1", loaded1); end
    wr_data = 12'hBAD;
    repeat (3) @(negedge clk);
    wr_valid = 1'b0;
    exp_loaded = 1'b1;
  endtask

  task automatic test_read_map();
    drive_pix(1, 5, 1'b1);
    drive_pix(3, 7, 1'b1);
    drive_pix(0, 8, 1'b1);
    drive_pix(2, 3, 1'b0);
    drive_pix(0, 0, 1'b1);
    drive_pix(1, 15, 1'b1);
    drive_pix(600, 900, 1'b1);
    drive_pix(3, 0, 1'b1);
    drive_pix(2, 6, 1'b1);
    drain();
  endtask

  task automatic test_back_to_back();
    drive_pix(0, 2, 1'b1);
    drive_pix(0, 3, 1'b1);
    for (int c = 0; c < 20; c++) drive_pix(3, c, 1'b1);
    for (int c = 1020; c < 1024; c++) drive_pix(1023, c, 1'b1);
    drain();
    vectors++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      errors++;
      $display("FAIL sweep_drain got pending=%0d/%0d want 0/0", sb0.size(), sb1.size());
    end
  endtask

`ifdef TILE_BORDER_EN
  task automatic test_border();
    drive_pix(0, 1, 1'b1);
    drive_pix(1, 1, 1'b1);
    drive_pix(0, 0, 1'b1);
    drive_pix(2, 6, 1'b1);
    drain();
  endtask
`endif

  task automatic test_restart();
    int got;
    exp_loaded = 1'b0;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    stream(10, 12'h700, 0, got);
    load_start = 1'b1;
    wr_valid   = 1'b1;
    wr_data    = 12'hEEE;
    @(negedge clk);
    load_start = 1'b0;
    wr_valid   = 1'b0;
    vectors++;
    if (loaded !== 1'b0 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL restart_state got loaded=%b wr_ready=%b want 0 1", loaded, wr_ready);
    end
    drive_pix(1, 5, 1'b1);
    drive_pix(0, 0, 1'b1);
    drain();
    stream(DEPTH, 12'h200, 40, got);
    vectors++;
    if (loaded !== 1'b1 || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL restart_done got loaded=%b wr_ready=%b want 1 0", loaded, wr_ready);
    end
    exp_loaded = 1'b1;
    drive_pix(0, 0, 1'b1);
    drive_pix(1, 5, 1'b1);
    drive_pix(3, 7, 1'b1);
    drive_pix(2, 1, 1'b1);
    drive_pix(1, 3, 1'b1);
    drain();
  endtask

  task automatic test_rst_midload();
    int got;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    stream(5, 12'h300, 0, got);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_loaded = 1'b0;
    vectors++;
    if (wr_ready !== 1'b0 || loaded !== 1'b0) begin
      errors++;
      $display("FAIL rst_midload got wr_ready=%b loaded=%b want 0 0", wr_ready, loaded);
    end
    wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    vectors++;
    if (wr_ready !== 1'b0) begin errors++; $display("FAIL rst_idle_ready got=%b want=0", wr_ready); end
    drive_pix(1, 5, 1'b1);
    drive_pix(3, 7, 1'b1);
    drain();
  endtask

  initial begin
    rst        = 1'b1;
    row        = '0;
    col        = '0;
    video_on   = 1'b0;
    load_start = 1'b0;
    wr_valid   = 1'b0;
    wr_data    = '0;
    test_reset();
    test_load();
    test_read_map();
    test_back_to_back();
`ifdef TILE_BORDER_EN
    test_border();
`endif
    test_restart();
    test_rst_midload();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
